mem_arbiter: RTL

- Shares one unified single-port memory between the CPU's instruction-fetch port and its load/store data port.
- Grants one requester at a time, with at most one outstanding transaction.
- Registers the winning request onto the memory side and returns a one-cycle ack with read data to the winner.
- Data port has priority; a streak limiter prevents fetch starvation.

---
 rtl/mem_arbiter.sv | 265 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Purpose  : Shares one single-port memory between a CPU instruction-fetch
//            port (i_*) and a load/store data port (d_*). One transaction is
//            in flight at a time. The data port wins contention, but after
//            STREAK_MAX consecutive data grants with a fetch pending, the
//            fetch port is forced through.
// Ports    : clk, reset (async, active-low)
//            i_req/i_addr -> i_ack/i_rdata/i_err           fetch port
//            d_req/d_we/d_addr/d_wdata/d_be
//                         -> d_ack/d_rdata/d_err           data port
//            m_req/m_we/m_addr/m_wdata/m_be <- m_done/m_rdata  memory side
//            gnt_d : 1 while the current or most recent grant is data
// Options  : MEM_ARB_TIMEOUT_EN - abort an ISSUE that sees no m_done within
//            TIMEOUT cycles and return ack+err with zeroed read data.
//            Undefined: ISSUE waits forever and i_err/d_err are tied to 0.
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned STREAK_MAX = 4,
  parameter int unsigned TIMEOUT    = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  // fetch port
  input  logic                  i_req,
  input  logic [ADDR_W-1:0]     i_addr,
  output logic                  i_ack,
  output logic [DATA_W-1:0]     i_rdata,
  output logic                  i_err,
  // data port
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [ADDR_W-1:0]     d_addr,
  input  logic [DATA_W-1:0]     d_wdata,
  input  logic [DATA_W/8-1:0]   d_be,
  output logic                  d_ack,
  output logic [DATA_W-1:0]     d_rdata,
  output logic                  d_err,
  // memory side
  output logic                  m_req,
  output logic                  m_we,
  output logic [ADDR_W-1:0]     m_addr,
  output logic [DATA_W-1:0]     m_wdata,
  output logic [DATA_W/8-1:0]   m_be,
  input  logic                  m_done,
  input  logic [DATA_W-1:0]     m_rdata,
  output logic                  gnt_d
);

  localparam int unsigned STRK_W = $clog2(STREAK_MAX + 1);
  localparam logic [STRK_W-1:0] c_STREAK_MAX = STRK_W'(STREAK_MAX);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [STRK_W-1:0]     r_streak;

  logic                  r_m_req;
  logic                  r_m_we;
  logic [ADDR_W-1:0]     r_m_addr;
  logic [DATA_W-1:0]     r_m_wdata;
  logic [DATA_W/8-1:0]   r_m_be;
  logic                  r_gnt_d;
  logic                  r_i_ack;
  logic                  r_d_ack;
  logic [DATA_W-1:0]     r_i_rdata;
  logic [DATA_W-1:0]     r_d_rdata;

  logic                  w_grant;     // a winner is chosen this IDLE cycle
  logic                  w_win_d;     // ... and it is the data port
  logic                  w_complete;  // memory finished the transaction
  logic                  w_abort;     // transaction abandoned by the timeout

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);
  // Abort fires in the ISSUE cycle whose increment would make the count
  // reach TIMEOUT; an m_done in that same cycle takes precedence.
  localparam logic [TMO_W-1:0] c_TMO_LAST = TMO_W'(TIMEOUT - 1);
  logic [TMO_W-1:0]      r_tmo;
  logic                  r_i_err;
  logic                  r_d_err;
`endif

  // --------------------------------------------------------------------------
  // Next-state / decision logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    w_win_d     = 1'b0;
    w_complete  = 1'b0;
    w_abort     = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_req || d_req) begin
          w_grant     = 1'b1;
          // Data wins unless a fetch is waiting and the streak is exhausted.
          w_win_d     = d_req && !(i_req && (r_streak == c_STREAK_MAX));
          w_state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        if (m_done) begin
          w_complete  = 1'b1;
          w_state_nxt = RESP;
        end
`ifdef MEM_ARB_TIMEOUT_EN
        else if (r_tmo == c_TMO_LAST) begin
          w_abort     = 1'b1;
          w_state_nxt = RESP;
        end
`endif
      end
      RESP: begin
        // No grant here: a request still held high is only seen next IDLE.
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Streak limiter: counts data grants made while a fetch is waiting.
  // Any IDLE cycle without a pending fetch, or any fetch grant, clears it.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_streak <= '0;
    end else if (r_state == IDLE) begin
      if (w_grant && w_win_d && i_req) begin
        if (r_streak != c_STREAK_MAX) begin
          r_streak <= r_streak + STRK_W'(1);
        end
      end else begin
        r_streak <= '0;
      end
    end
  end

`ifdef MEM_ARB_TIMEOUT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_tmo <= '0;
    end else if (w_grant) begin
      r_tmo <= '0;
    end else if ((r_state == ISSUE) && !m_done) begin
      r_tmo <= r_tmo + TMO_W'(1);
    end
  end
`endif

  // --------------------------------------------------------------------------
  // Memory-side request registers and response path
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_m_req   <= 1'b0;
      r_m_we    <= 1'b0;
      r_m_addr  <= '0;
      r_m_wdata <= '0;
      r_m_be    <= '0;
      r_gnt_d   <= 1'b0;
      r_i_ack   <= 1'b0;
      r_d_ack   <= 1'b0;
      r_i_rdata <= '0;
      r_d_rdata <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
      r_i_err   <= 1'b0;
      r_d_err   <= 1'b0;
`endif
    end else begin
      // Acks (and errs) are single-cycle pulses during RESP.
      r_i_ack <= 1'b0;
      r_d_ack <= 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
      r_i_err <= 1'b0;
      r_d_err <= 1'b0;
`endif
      if (w_grant) begin
        r_m_req <= 1'b1;
        r_gnt_d <= w_win_d;
        if (w_win_d) begin
          r_m_we    <= d_we;
          r_m_addr  <= d_addr;
          r_m_wdata <= d_wdata;
          r_m_be    <= d_be;
        end else begin
          // Fetches are always full-word reads; no stale store data is driven.
          r_m_we    <= 1'b0;
          r_m_addr  <= i_addr;
          r_m_wdata <= '0;
          r_m_be    <= '1;
        end
      end
      if (w_complete) begin
        r_m_req <= 1'b0;
        if (r_gnt_d) begin
          r_d_ack <= 1'b1;
          if (!r_m_we) begin
            r_d_rdata <= m_rdata;
          end
        end else begin
          r_i_ack   <= 1'b1;
          r_i_rdata <= m_rdata;
        end
      end
`ifdef MEM_ARB_TIMEOUT_EN
      if (w_abort) begin
        r_m_req <= 1'b0;
        if (r_gnt_d) begin
          r_d_ack   <= 1'b1;
          r_d_err   <= 1'b1;
          r_d_rdata <= '0;
        end else begin
          r_i_ack   <= 1'b1;
          r_i_err   <= 1'b1;
          r_i_rdata <= '0;
        end
      end
`endif
    end
  end

  assign m_req   = r_m_req;
  assign m_we    = r_m_we;
  assign m_addr  = r_m_addr;
  assign m_wdata = r_m_wdata;
  assign m_be    = r_m_be;
  assign gnt_d   = r_gnt_d;
  assign i_ack   = r_i_ack;
  assign d_ack   = r_d_ack;
  assign i_rdata = r_i_rdata;
  assign d_rdata = r_d_rdata;
`ifdef MEM_ARB_TIMEOUT_EN
  assign i_err   = r_i_err;
  assign d_err   = r_d_err;
`else
  assign i_err   = 1'b0;
  assign d_err   = 1'b0;
`endif

endmodule
`default_nettype wire
